// File: rtl/sw_debounce_if.sv
// Switch-conditioning signal bundle: raw pins in, debounced level and strobes out.
interface sw_debounce_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output sw_raw,
        input  sw_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser plus an independent
// hold-time debounce counter per bit, with registered rise/fall/changed strobes.
module sw_debounce #(
    parameter int unsigned      WIDTH           = 10,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    sw_debounce_if.slave  bus
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_sw_out_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Per-bit hold counter: restart whenever the synchronised level matches the
    // committed one, commit (and strobe) once it has differed for D edges.
    always_comb begin
        w_sw_out_nxt = r_sw_out;
        w_rise_nxt   = '0;
        w_fall_nxt   = '0;
        w_cnt_nxt    = r_cnt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_sw_out[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i]    = '0;
                w_sw_out_nxt[i] = r_sync2[i];
                w_rise_nxt[i]   = r_sync2[i];
                w_fall_nxt[i]   = ~r_sync2[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Synchroniser, debounce state and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= RESET_VAL;
            r_sync2   <= RESET_VAL;
            r_sw_out  <= RESET_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= bus.sw_raw;
            r_sync2   <= r_sync1;
            r_sw_out  <= w_sw_out_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= |(w_rise_nxt | w_fall_nxt);
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.sw_out  = r_sw_out;
    assign bus.rise    = r_rise;
    assign bus.fall    = r_fall;
    assign bus.changed = r_changed;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=10, DEBOUNCE_CYCLES=4, RESET_VAL=0.
module tb_sw_debounce;

    logic clk;
    logic reset_n;

    int checks;
    int failures;

    typedef struct {
        logic [9:0] raw;
        logic [9:0] out;
        logic [9:0] rise;
        logic [9:0] fall;
        logic       ch;
    } vec_t;

    vec_t vecs[$];

    sw_debounce_if #(.WIDTH(10)) u_if ();

    sw_debounce #(
        .WIDTH(10),
        .DEBOUNCE_CYCLES(4),
        .RESET_VAL(10'h000)
    ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [9:0] raw, input logic [9:0] out,
                       input logic [9:0] rise, input logic [9:0] fall, input logic ch);
        vec_t v;
        v.raw = raw; v.out = out; v.rise = rise; v.fall = fall; v.ch = ch;
        vecs.push_back(v);
    endtask

    task automatic addn(input int n, input logic [9:0] raw, input logic [9:0] out);
        for (int k = 0; k < n; k++) add(raw, out, 10'h000, 10'h000, 1'b0);
    endtask

    task automatic check(input string name, input int idx, input logic [9:0] eo,
                         input logic [9:0] er, input logic [9:0] ef, input logic ec);
        checks++;
        if (u_if.sw_out !== eo || u_if.rise !== er || u_if.fall !== ef || u_if.changed !== ec) begin
            failures++;
            $display("FAIL %s[%0d] got out=%h rise=%h fall=%h ch=%b, expected out=%h rise=%h fall=%h ch=%b",
                     name, idx, u_if.sw_out, u_if.rise, u_if.fall, u_if.changed, eo, er, ef, ec);
        end
    endtask

    // Drive raw before the next edge, sample 1 time unit after it.
    task automatic step(input string name, input int idx, input logic [9:0] raw,
                        input logic [9:0] eo, input logic [9:0] er,
                        input logic [9:0] ef, input logic ec);
        u_if.sw_raw = raw;
        @(posedge clk);
        #1;
        check(name, idx, eo, er, ef, ec);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Test 2: bit 0 rises, commits at edge 5
        addn(5, 10'h001, 10'h000);
        add(10'h001, 10'h001, 10'h001, 10'h000, 1'b1);
        add(10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
        // Test 3: bit 3 bounces 1,0,1,0 then holds 1
        add(10'h009, 10'h001, 10'h000, 10'h000, 1'b0);
        add(10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
        add(10'h009, 10'h001, 10'h000, 10'h000, 1'b0);
        add(10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
        addn(5, 10'h009, 10'h001);
        add(10'h009, 10'h009, 10'h008, 10'h000, 1'b1);
        add(10'h009, 10'h009, 10'h000, 10'h000, 1'b0);
        // Test 4: all bits high, then all bits low on one edge
        addn(5, 10'h3FF, 10'h009);
        add(10'h3FF, 10'h3FF, 10'h3F6, 10'h000, 1'b1);
        add(10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0);
        addn(5, 10'h000, 10'h3FF);
        add(10'h000, 10'h000, 10'h000, 10'h3FF, 1'b1);
        add(10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
        // Test 5: bit 9 glitch of 3 cycles never commits
        addn(3, 10'h200, 10'h000);
        addn(5, 10'h000, 10'h000);

        // Test 1: reset with quiet inputs
        reset_n    = 1'b0;
        u_if.sw_raw = 10'h000;
        #1;
        check("reset_async", 0, 10'h000, 10'h000, 10'h000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", k, 10'h000, 10'h000, 10'h000, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++)
            step("quiet", k, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);

        // Tests 2-5 from the vector table
        for (int k = 0; k < vecs.size(); k++)
            step("vec", k, vecs[k].raw, vecs[k].out, vecs[k].rise, vecs[k].fall, vecs[k].ch);

        // Test 6: commit bit 0 so reset has a visible effect, then start bit 5
        for (int k = 0; k < 5; k++)
            step("pre6", k, 10'h001, 10'h000, 10'h000, 10'h000, 1'b0);
        step("pre6", 5, 10'h001, 10'h001, 10'h001, 10'h000, 1'b1);
        for (int k = 0; k < 4; k++)
            step("pend5", k, 10'h021, 10'h001, 10'h000, 10'h000, 1'b0);
        // bit 5 counter is at 2 here; reset mid-count
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid", 0, 10'h000, 10'h000, 10'h000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_mid_hold", k, 10'h000, 10'h000, 10'h000, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++)
            step("post_rst", k, 10'h021, 10'h000, 10'h000, 10'h000, 1'b0);
        step("post_rst", 5, 10'h021, 10'h021, 10'h021, 10'h000, 1'b1);
        step("post_rst", 6, 10'h021, 10'h021, 10'h000, 10'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
